hx8352_fill_sequencer: RTL and testbench

//  Sequences one rectangular solid-colour fill on the HX8352 panel.

---
 rtl/hx8352_fill_sequencer.sv | 157 +++++++++++++++
 tb/tb_hx8352_fill_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hx8352_fill_sequencer.sv
// rtl/hx8352_fill_sequencer.sv - one rectangular solid-colour fill on the HX8352 panel
// Emits column/row window, RAM-write command and N colour words through the bus controller.
module hx8352_fill_sequencer #(
    parameter int MAX_X = 239,
    parameter int MAX_Y = 399
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x0,
    input  logic [8:0]  req_x1,
    input  logic [8:0]  req_y0,
    input  logic [8:0]  req_y1,
    input  logic [15:0] req_color,
    output logic        done,
    output logic        err,
    output logic [15:0] bus_data,
    output logic        bus_rs,
    output logic        bus_step,
    input  logic        bus_busy,
    output logic        lcd_cs
);

    localparam logic [8:0] MAX_X9   = 9'(MAX_X);
    localparam logic [8:0] MAX_Y9   = 9'(MAX_Y);
    localparam logic [3:0] IDX_RAMWR = 4'd10;
    localparam logic [3:0] IDX_PIXEL = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REJECT,
        S_CS_SETUP,
        S_ISSUE,
        S_WAIT,
        S_CS_HOLD,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    logic [3:0]  idx;
    logic [16:0] pix_cnt;
    logic        last_word;
    logic        skip;
    logic        load_word;
    logic        bad_window;
    logic [8:0]  width, height;
    logic [16:0] n_total;
    logic [15:0] word_data;
    logic        word_rs;

    assign bad_window = (x0 > x1) || (y0 > y1) || (x1 > MAX_X9) || (y1 > MAX_Y9);
    assign width      = x1 - x0 + 9'd1;
    assign height     = y1 - y0 + 9'd1;
    assign n_total    = {8'd0, width} * {8'd0, height};

    // idx 0..10 are the window/command header; idx 11 means "colour words".
    always_comb begin
        word_data = color;
        word_rs   = 1'b1;
        case (idx)
            4'd0:    begin word_data = 16'h002A; word_rs = 1'b0; end
            4'd1:    word_data = {15'd0, x0[8]};
            4'd2:    word_data = {8'd0, x0[7:0]};
            4'd3:    word_data = {15'd0, x1[8]};
            4'd4:    word_data = {8'd0, x1[7:0]};
            4'd5:    begin word_data = 16'h002B; word_rs = 1'b0; end
            4'd6:    word_data = {15'd0, y0[8]};
            4'd7:    word_data = {8'd0, y0[7:0]};
            4'd8:    word_data = {15'd0, y1[8]};
            4'd9:    word_data = {8'd0, y1[7:0]};
            4'd10:   begin word_data = 16'h002C; word_rs = 1'b0; end
            default: begin word_data = color; word_rs = 1'b1; end
        endcase
    end

    always_comb begin
        state_n   = state;
        load_word = 1'b0;
        case (state)
            S_IDLE:     if (req_valid) state_n = S_CHECK;
            S_CHECK:    state_n = bad_window ? S_REJECT : S_CS_SETUP;
            S_REJECT:   state_n = S_IDLE;
            S_CS_SETUP: begin
                if (!bus_busy) begin
                    state_n   = S_ISSUE;
                    load_word = 1'b1;
                end
            end
            S_ISSUE:    state_n = S_WAIT;
            S_WAIT: begin
                // first WAIT cycle is skipped: the controller raises busy one cycle after the step
                if (!skip && !bus_busy) begin
                    if (last_word) begin
                        state_n = S_CS_HOLD;
                    end else begin
                        state_n   = S_ISSUE;
                        load_word = 1'b1;
                    end
                end
            end
            S_CS_HOLD:  state_n = S_DONE;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign err       = (state == S_REJECT);
    assign done      = (state == S_DONE);
    assign bus_step  = (state == S_ISSUE);
    assign lcd_cs    = !((state == S_CS_SETUP) || (state == S_ISSUE) ||
                         (state == S_WAIT) || (state == S_CS_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            x0        <= '0;
            x1        <= '0;
            y0        <= '0;
            y1        <= '0;
            color     <= '0;
            idx       <= '0;
            pix_cnt   <= '0;
            last_word <= 1'b0;
            skip      <= 1'b0;
            bus_data  <= '0;
            bus_rs    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req_valid) begin
                x0        <= req_x0;
                x1        <= req_x1;
                y0        <= req_y0;
                y1        <= req_y1;
                color     <= req_color;
                idx       <= '0;
                last_word <= 1'b0;
            end
            skip <= (state == S_ISSUE);
            if (load_word) begin
                bus_data <= word_data;
                bus_rs   <= word_rs;
                if (idx != IDX_PIXEL) idx <= idx + 4'd1;
                if (idx == IDX_RAMWR) pix_cnt <= n_total;
                if (idx == IDX_PIXEL) begin
                    pix_cnt   <= pix_cnt - 17'd1;
                    last_word <= (pix_cnt == 17'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hx8352_fill_sequencer.sv
// tb/tb_hx8352_fill_sequencer.sv - directed self-checking bench for hx8352_fill_sequencer
module tb_hx8352_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_x0 = '0, req_x1 = '0, req_y0 = '0, req_y1 = '0;
    logic [15:0] req_color = '0;
    logic        done, err;
    logic [15:0] bus_data;
    logic        bus_rs, bus_step, bus_busy, lcd_cs;

    int          n_cmp = 0;
    int          n_bad = 0;

    // bus controller model: busy for busy_len cycles starting the cycle after a step
    int          busy_len = 3;
    int          bcnt = 0;
    logic        hold_busy = 1'b0;

    // monitor log
    logic [15:0] step_data[$];
    logic        step_rs[$];
    int          step_count = 0;
    int          done_count = 0;
    int          err_count = 0;
    int          cs_fall = 0;
    int          viol_cs = 0;
    int          viol_busy = 0;
    logic        done_cs = 1'b0;
    logic        prev_cs = 1'b1;

    logic [15:0] t1_data [12] = '{16'h002A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h002B,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h002C, 16'hF800};
    logic        t1_rs [12]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    hx8352_fill_sequencer #(.MAX_X(239), .MAX_Y(399)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_x1    (req_x1),
        .req_y0    (req_y0),
        .req_y1    (req_y1),
        .req_color (req_color),
        .done      (done),
        .err       (err),
        .bus_data  (bus_data),
        .bus_rs    (bus_rs),
        .bus_step  (bus_step),
        .bus_busy  (bus_busy),
        .lcd_cs    (lcd_cs)
    );

    always #5 clk = ~clk;

    assign bus_busy = (bcnt != 0) || hold_busy;

    always @(posedge clk or posedge rst) begin
        if (rst)            bcnt <= 0;
        else if (bus_step)  bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always @(negedge clk) begin
        if (bus_step) begin
            step_data.push_back(bus_data);
            step_rs.push_back(bus_rs);
            step_count++;
            if (lcd_cs)   viol_cs++;
            if (bus_busy) viol_busy++;
        end
        if (done) begin
            done_count++;
            done_cs = lcd_cs;
        end
        if (err) err_count++;
        if (!lcd_cs && prev_cs) cs_fall++;
        prev_cs = lcd_cs;
    end

    function automatic logic [16:0] ref_word(input int i, input logic [8:0] x0, input logic [8:0] x1,
                                             input logic [8:0] y0, input logic [8:0] y1,
                                             input logic [15:0] c);
        case (i)
            0:  return {1'b0, 16'h002A};
            1:  return {1'b1, 15'd0, x0[8]};
            2:  return {1'b1, 8'd0, x0[7:0]};
            3:  return {1'b1, 15'd0, x1[8]};
            4:  return {1'b1, 8'd0, x1[7:0]};
            5:  return {1'b0, 16'h002B};
            6:  return {1'b1, 15'd0, y0[8]};
            7:  return {1'b1, 8'd0, y0[7:0]};
            8:  return {1'b1, 15'd0, y1[8]};
            9:  return {1'b1, 8'd0, y1[7:0]};
            10: return {1'b0, 16'h002C};
            default: return {1'b1, c};
        endcase
    endfunction

    // returns just after the accepting clock edge; request fields are then scrambled
    task automatic start_fill(input logic [8:0] x0, input logic [8:0] x1, input logic [8:0] y0,
                              input logic [8:0] y1, input logic [15:0] c, output bit ok);
        @(posedge clk); #1;
        req_x0 = x0; req_x1 = x1; req_y0 = y0; req_y1 = y1; req_color = c;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        req_x0 = 9'h1AB; req_x1 = 9'h055; req_y0 = 9'h1F0; req_y1 = 9'h003; req_color = 16'hDEAD;
    endtask

    task automatic wait_done(input int base, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc && !ok; k++) begin
            @(posedge clk); #1;
            if (done_count > base) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        n_cmp++; if ({done, err, bus_step} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got=%b want=000", {done, err, bus_step}); end
        n_cmp++; if ({bus_rs, bus_data} !== 17'd0) begin n_bad++; $display("FAIL reset_bus got=%h want=0", {bus_rs, bus_data}); end
        n_cmp++; if (lcd_cs !== 1'b1) begin n_bad++; $display("FAIL reset_cs got=%b want=1", lcd_cs); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({req_ready, lcd_cs, bus_step} !== 3'b110) begin n_bad++; $display("FAIL idle_after_reset got=%b want=110", {req_ready, lcd_cs, bus_step}); end
    endtask

    task automatic test_single_pixel;
        int b, d, f; bit ok;
        busy_len = 3;
        b = step_count; d = done_count; f = cs_fall;
        start_fill(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800, ok);
        wait_done(d, 300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_done_timeout got=0 want=1"); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_after_done got=%b want=1", req_ready); end
        n_cmp++; if (done_cs !== 1'b1) begin n_bad++; $display("FAIL single_cs_at_done got=%b want=1", done_cs); end
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (step_count - b !== 12) begin n_bad++; $display("FAIL single_steps got=%0d want=12", step_count - b); end
        if (step_count - b >= 12)
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if ({step_rs[b+i], step_data[b+i]} !== {t1_rs[i], t1_data[i]}) begin
                    n_bad++; $display("FAIL single_word%0d got=%b/%h want=%b/%h", i, step_rs[b+i], step_data[b+i], t1_rs[i], t1_data[i]);
                end
            end
        n_cmp++; if (done_count - d !== 1) begin n_bad++; $display("FAIL single_done_count got=%0d want=1", done_count - d); end
        n_cmp++; if (cs_fall - f !== 1) begin n_bad++; $display("FAIL single_cs_windows got=%0d want=1", cs_fall - f); end
    endtask

    task automatic test_full_screen_header;
        int b, d, bad_px; bit ok;
        busy_len = 0;
        b = step_count; d = done_count;
        start_fill(9'd0, 9'd239, 9'd0, 9'd399, 16'h07E0, ok);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(posedge clk); #1;
            if (step_count - b >= 111) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_progress_timeout got=%0d want=111", step_count - b); end
        n_cmp++; if (lcd_cs !== 1'b0) begin n_bad++; $display("FAIL full_cs_low got=%b want=0", lcd_cs); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({lcd_cs, bus_step, req_ready} !== 3'b101) begin n_bad++; $display("FAIL full_abort got=%b want=101", {lcd_cs, bus_step, req_ready}); end
        @(negedge clk); rst = 1'b0;
        if (step_count - b >= 111) begin
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if ({step_rs[b+i], step_data[b+i]} !== ref_word(i, 9'd0, 9'd239, 9'd0, 9'd399, 16'h07E0)) begin
                    n_bad++; $display("FAIL full_hdr%0d got=%b/%h want=%h", i, step_rs[b+i], step_data[b+i], ref_word(i, 9'd0, 9'd239, 9'd0, 9'd399, 16'h07E0));
                end
            end
            bad_px = 0;
            for (int i = 11; i < 111; i++) if ({step_rs[b+i], step_data[b+i]} !== {1'b1, 16'h07E0}) bad_px++;
            n_cmp++; if (bad_px != 0) begin n_bad++; $display("FAIL full_pixels got=%0d_bad want=0_bad", bad_px); end
        end
        n_cmp++; if (done_count - d !== 0) begin n_bad++; $display("FAIL full_no_done got=%0d want=0", done_count - d); end
    endtask

    task automatic test_wide_fill;
        int b, d, f, bad_px; bit ok;
        busy_len = 1;
        b = step_count; d = done_count; f = cs_fall;
        start_fill(9'd0, 9'd239, 9'd398, 9'd399, 16'h1234, ok);
        wait_done(d, 4000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wide_done_timeout got=0 want=1"); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (step_count - b !== 491) begin n_bad++; $display("FAIL wide_steps got=%0d want=491", step_count - b); end
        if (step_count - b >= 491) begin
            bad_px = 0;
            for (int i = 0; i < 491; i++)
                if ({step_rs[b+i], step_data[b+i]} !== ref_word(i, 9'd0, 9'd239, 9'd398, 9'd399, 16'h1234)) bad_px++;
            n_cmp++; if (bad_px != 0) begin n_bad++; $display("FAIL wide_words got=%0d_bad want=0_bad", bad_px); end
            n_cmp++; if (step_data[b+8] !== 16'h0001 || step_data[b+9] !== 16'h008F) begin
                n_bad++; $display("FAIL wide_y1 got=%h/%h want=0001/008F", step_data[b+8], step_data[b+9]);
            end
        end
        n_cmp++; if (cs_fall - f !== 1) begin n_bad++; $display("FAIL wide_cs_windows got=%0d want=1", cs_fall - f); end
    endtask

    task automatic test_reject;
        logic [8:0] tx0 [3] = '{9'd10, 9'd0, 9'd0};
        logic [8:0] tx1 [3] = '{9'd5,  9'd0, 9'd240};
        logic [8:0] ty1 [3] = '{9'd0,  9'd400, 9'd0};
        int b, e; bit ok; logic e1, e2, cs_hi;
        for (int t = 0; t < 3; t++) begin
            b = step_count; e = err_count; cs_hi = 1'b1;
            start_fill(tx0[t], tx1[t], 9'd0, ty1[t], 16'hFFFF, ok);
            @(negedge clk); e1 = err; cs_hi &= lcd_cs;
            @(negedge clk); e2 = err; cs_hi &= lcd_cs;
            for (int k = 0; k < 5; k++) begin @(negedge clk); cs_hi &= lcd_cs; end
            @(posedge clk); #1;
            n_cmp++; if ({e1, e2} !== 2'b01) begin n_bad++; $display("FAIL reject%0d_err_timing got=%b want=01", t, {e1, e2}); end
            n_cmp++; if (err_count - e !== 1) begin n_bad++; $display("FAIL reject%0d_err_count got=%0d want=1", t, err_count - e); end
            n_cmp++; if (step_count - b !== 0) begin n_bad++; $display("FAIL reject%0d_steps got=%0d want=0", t, step_count - b); end
            n_cmp++; if (cs_hi !== 1'b1) begin n_bad++; $display("FAIL reject%0d_cs got=%b want=1", t, cs_hi); end
        end
    endtask

    task automatic test_busy_stall;
        int b, d, early; bit ok; logic s0, s1;
        busy_len = 2;
        hold_busy = 1'b1;
        b = step_count; d = done_count; early = 0;
        start_fill(9'd3, 9'd3, 9'd4, 9'd4, 16'h00FF, ok);
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus_step) early++; end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL stall_early_steps got=%0d want=0", early); end
        n_cmp++; if (lcd_cs !== 1'b0) begin n_bad++; $display("FAIL stall_cs_setup got=%b want=0", lcd_cs); end
        @(posedge clk); #1 hold_busy = 1'b0;
        @(negedge clk); s0 = bus_step;
        @(negedge clk); s1 = bus_step;
        n_cmp++; if ({s0, s1} !== 2'b01) begin n_bad++; $display("FAIL stall_first_step got=%b want=01", {s0, s1}); end
        wait_done(d, 300, ok);
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (step_count - b !== 12) begin n_bad++; $display("FAIL stall_steps got=%0d want=12", step_count - b); end
        n_cmp++; if (viol_busy !== 0) begin n_bad++; $display("FAIL step_while_busy got=%0d want=0", viol_busy); end
    endtask

    task automatic test_reset_mid_fill;
        int b, d, bad_px; bit ok;
        busy_len = 2;
        b = step_count; d = done_count;
        start_fill(9'd0, 9'd9, 9'd0, 9'd9, 16'hAAAA, ok);
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(posedge clk); #1;
            if (step_count - b >= 61) ok = 1'b1;
        end
        n_cmp++; if (step_count - b !== 61) begin n_bad++; $display("FAIL mid_progress got=%0d want=61", step_count - b); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({lcd_cs, bus_step, req_ready, done, err} !== 5'b10100) begin
            n_bad++; $display("FAIL mid_abort got=%b want=10100", {lcd_cs, bus_step, req_ready, done, err});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (done_count - d !== 0) begin n_bad++; $display("FAIL mid_no_done got=%0d want=0", done_count - d); end
        b = step_count; d = done_count;
        start_fill(9'd5, 9'd6, 9'd7, 9'd8, 16'h5A5A, ok);
        wait_done(d, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_refill_timeout got=0 want=1"); end
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (step_count - b !== 15) begin n_bad++; $display("FAIL mid_refill_steps got=%0d want=15", step_count - b); end
        bad_px = 0;
        if (step_count - b >= 15)
            for (int i = 0; i < 15; i++)
                if ({step_rs[b+i], step_data[b+i]} !== ref_word(i, 9'd5, 9'd6, 9'd7, 9'd8, 16'h5A5A)) bad_px++;
        n_cmp++; if (bad_px != 0) begin n_bad++; $display("FAIL mid_refill_words got=%0d_bad want=0_bad", bad_px); end
    endtask

    task automatic test_back_to_back;
        int b, d, f, seen;
        busy_len = 1;
        b = step_count; d = done_count; f = cs_fall; seen = 0;
        @(posedge clk); #1;
        req_x0 = 9'd1; req_x1 = 9'd2; req_y0 = 9'd3; req_y1 = 9'd3; req_color = 16'hC0DE;
        req_valid = 1'b1;
        for (int k = 0; k < 800 && seen < 3; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk); #1;
        n_cmp++; if (seen != 3) begin n_bad++; $display("FAIL b2b_timeout got=%0d want=3", seen); end
        n_cmp++; if (done_count - d !== 3) begin n_bad++; $display("FAIL b2b_done got=%0d want=3", done_count - d); end
        n_cmp++; if (step_count - b !== 39) begin n_bad++; $display("FAIL b2b_steps got=%0d want=39", step_count - b); end
        n_cmp++; if (cs_fall - f !== 3) begin n_bad++; $display("FAIL b2b_cs_windows got=%0d want=3", cs_fall - f); end
        n_cmp++; if (viol_cs !== 0) begin n_bad++; $display("FAIL step_while_cs_high got=%0d want=0", viol_cs); end
    endtask

    initial begin
        test_reset;
        test_single_pixel;
        test_full_screen_header;
        test_wide_fill;
        test_reject;
        test_busy_stall;
        test_reset_mid_fill;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
